// File: rtl/sram_addr_pkg.sv
// Shared helpers for the SRAM frame-buffer address generator:
// width arithmetic, the buffer-index type and free-buffer selection.
package sram_addr_pkg;

  // Wide enough for any legal buffer count (1..4).
  typedef logic [1:0] buf_idx_t;

  function automatic int clog2_int(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int buf_width(input int num_buf);
    return max_int(1, clog2_int(num_buf));
  endfunction

  function automatic bit num_buf_ok(input int num_buf);
    return (num_buf >= 1) && (num_buf <= 4);
  endfunction

  // Finds the first buffer cyclically after cur that is neither rd nor pend.
  // The loop runs from the farthest candidate to the nearest so that the
  // nearest legal one is the last assignment and wins.
  function automatic bit next_free(input int num_buf, input int cur,
                                   input int rd, input int pend,
                                   output buf_idx_t nxt);
    int cand;
    next_free = 1'b0;
    nxt       = '0;
    for (int k = num_buf - 1; k >= 1; k--) begin
      cand = (cur + k) % num_buf;
      if ((cand != rd) && (cand != pend)) begin
        nxt       = buf_idx_t'(cand);
        next_free = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/xy_counter.sv
// Column/row raster counter for one frame. Clear wins over enable; the
// last-pixel flag describes the current position.
module xy_counter import sram_addr_pkg::*; #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  localparam int COL_W = clog2_int(H_ACTIVE),
  localparam int ROW_W = clog2_int(V_ACTIVE)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [COL_W-1:0] o_col,
  output logic [ROW_W-1:0] o_row,
  output logic             o_last
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_last, row_last;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  // Next position: restart on clear, otherwise step through the raster.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (i_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (i_en) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Position registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign o_col  = col_q;
  assign o_row  = row_q;
  assign o_last = col_last && row_last;

endmodule

// File: rtl/sram_frame_addr_gen.sv
// SRAM address generator for the VGA frame buffer: independent write and
// read raster pointers plus 1..4 buffer rotation with tear-free swaps at
// read-frame boundaries.
module sram_frame_addr_gen import sram_addr_pkg::*; #(
  parameter int ADDR_WIDTH = 20,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int NUM_BUF    = 2,
  localparam int COL_W = clog2_int(H_ACTIVE),
  localparam int ROW_W = clog2_int(V_ACTIVE),
  localparam int BUF_W = buf_width(NUM_BUF)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_n,
  input  logic                  i_rd_n,
  input  logic                  i_addr_inc,
  input  logic                  i_rd_sync,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [BUF_W-1:0]      o_rd_buf,
  output logic [BUF_W-1:0]      o_wr_buf,
  output logic                  o_wr_frame_done,
  output logic                  o_rd_frame_done,
  output logic                  o_wr_stall,
  output logic                  o_wr_drop
);

  localparam int               USED_W     = BUF_W + ROW_W + COL_W;
  localparam logic [BUF_W-1:0] WR_BUF_RST = (NUM_BUF > 1) ? BUF_W'(1) : '0;

  if (!num_buf_ok(NUM_BUF)) begin : g_bad_num_buf
    $error("sram_frame_addr_gen: NUM_BUF must be 1..4");
  end
  if (ADDR_WIDTH < USED_W) begin : g_bad_addr_width
    $error("sram_frame_addr_gen: ADDR_WIDTH too small for {buf,row,col}");
  end

  logic [COL_W-1:0] wr_col, rd_col;
  logic [ROW_W-1:0] wr_row, rd_row;
  logic             wr_last, rd_last;

  logic [BUF_W-1:0] wr_buf_q, wr_buf_d;
  logic [BUF_W-1:0] rd_buf_q, rd_buf_d;
  logic [BUF_W-1:0] pend_buf_q, pend_buf_d;
  logic             pending_q, pending_d;
  logic             stall_q, stall_d;

  logic             wr_adv, rd_adv, rd_wrap, swap;
  logic             found;
  buf_idx_t         nxt;

  // Write has priority over read; a stalled writer never moves.
  assign wr_adv  = !i_wr_n && !stall_q;
  assign rd_adv  = !i_rd_n && i_addr_inc && i_wr_n;
  assign rd_wrap = rd_adv && rd_last && !i_rd_sync;
  assign swap    = pending_q && (i_rd_sync || rd_wrap);

  xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_wr_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (wr_adv),
    .i_clr  (1'b0),
    .o_col  (wr_col),
    .o_row  (wr_row),
    .o_last (wr_last)
  );

  xy_counter #(.H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE)) u_rd_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_en   (rd_adv),
    .i_clr  (i_rd_sync),
    .o_col  (rd_col),
    .o_row  (rd_row),
    .o_last (rd_last)
  );

  // Buffer allocation: the read swap is resolved first so a writer finishing
  // in the same cycle chooses its next buffer against the new display buffer.
  always_comb begin
    rd_buf_d   = rd_buf_q;
    wr_buf_d   = wr_buf_q;
    pend_buf_d = pend_buf_q;
    pending_d  = pending_q;
    stall_d    = stall_q;
    found      = 1'b0;
    nxt        = '0;
    if (swap) begin
      rd_buf_d  = pend_buf_q;
      pending_d = 1'b0;
      if (stall_q) begin
        wr_buf_d = rd_buf_q;
        stall_d  = 1'b0;
      end
    end
    if (wr_adv && wr_last && (NUM_BUF > 1)) begin
      pend_buf_d = wr_buf_q;
      pending_d  = 1'b1;
      found = next_free(NUM_BUF, int'(wr_buf_q), int'(rd_buf_d),
                        int'(wr_buf_q), nxt);
      if (found) wr_buf_d = BUF_W'(nxt);
      else       stall_d  = 1'b1;
    end
  end

  // Buffer bookkeeping registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_buf_q   <= '0;
      wr_buf_q   <= WR_BUF_RST;
      pend_buf_q <= '0;
      pending_q  <= 1'b0;
      stall_q    <= 1'b0;
    end else begin
      rd_buf_q   <= rd_buf_d;
      wr_buf_q   <= wr_buf_d;
      pend_buf_q <= pend_buf_d;
      pending_q  <= pending_d;
      stall_q    <= stall_d;
    end
  end

  assign o_addr = i_wr_n ? ADDR_WIDTH'({rd_buf_q, rd_row, rd_col})
                         : ADDR_WIDTH'({wr_buf_q, wr_row, wr_col});
  assign o_rd_buf        = rd_buf_q;
  assign o_wr_buf        = wr_buf_q;
  assign o_wr_frame_done = wr_adv && wr_last;
  assign o_rd_frame_done = rd_wrap;
  assign o_wr_stall      = stall_q;
  assign o_wr_drop       = !i_wr_n && stall_q;

endmodule

// File: doc/sram_frame_addr_gen.md
Name: sram_frame_addr_gen

Overview:
- Parametrised SRAM address generator for the VGA frame-buffer path.
- Keeps independent write (image load) and read (VGA scan) pointers as column/row counters.
- Supports 1–4 frame buffers with tear-free buffer swapping at read-frame boundaries.
- Drives the single SRAM address bus, and flags frame completion, writer stall and dropped writes to the controller.

Parameters:
- ADDR_WIDTH, 20, SRAM address width; must be >= BUF_W+ROW_W+COL_W.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- NUM_BUF, 2, number of frame buffers, 1..4.
- Derived: COL_W=clog2(H_ACTIVE), ROW_W=clog2(V_ACTIVE), BUF_W=max(1,clog2(NUM_BUF)).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_wr_n  in  1  SRAM write strobe, active low
- i_rd_n  in  1  SRAM read enable, active low
- i_addr_inc  in  1  VGA active-region pixel advance
- i_rd_sync  in  1  read frame restart (vsync), 1-cycle pulse
- o_addr  out  ADDR_WIDTH  SRAM address of current access
- o_rd_buf  out  BUF_W  buffer being displayed
- o_wr_buf  out  BUF_W  buffer being written
- o_wr_frame_done  out  1  1-cycle pulse: write frame complete
- o_rd_frame_done  out  1  1-cycle pulse: read frame wrapped
- o_wr_stall  out  1  no free buffer; writes ignored
- o_wr_drop  out  1  1-cycle pulse per ignored write

Behaviour:
- Address format: zero-extend {buf, row, col}. Line pitch is 2**COL_W, so non-power-of-two widths leave gaps.
- o_addr is combinational:
  - i_wr_n=0: write address {wr_buf, wr_row, wr_col}.
  - otherwise: read address {rd_buf, rd_row, rd_col}.
- Pointers advance on the clock edge that ends an access, so the first access uses col=0,row=0.
- Write advance:
  - Condition: every cycle with i_wr_n=0 and o_wr_stall=0.
  - col increments; at col=H_ACTIVE-1, col←0 and row increments.
  - At the last pixel (col=H-1, row=V-1): wrap to 0,0, pulse o_wr_frame_done, pend_buf←wr_buf, pending←1.
  - Next wr_buf: the first buffer cyclically after wr_buf that is neither rd_buf nor the new pend_buf.
  - If no such buffer exists, o_wr_stall←1 from the next cycle.
- Stall:
  - Write strobes while stalled do not move pointers; each one pulses o_wr_drop in that cycle.
  - Stall clears in the cycle after a read swap frees a buffer. wr_buf← freed buffer, pointers at 0,0.
- Read advance:
  - Condition: i_rd_n=0, i_addr_inc=1 and i_wr_n=1. Write has priority; a simultaneous read does not advance.
  - Same col/row wrap rule as the write side.
  - At the last pixel: wrap to 0,0 and pulse o_rd_frame_done. If pending, rd_buf←pend_buf, pending←0, and the old rd_buf becomes free.
- i_rd_sync: forces read col/row←0 and performs the same pending swap. No o_rd_frame_done pulse. Has priority over read advance in the same cycle.
- i_rd_n=1: read pointers hold (pause, not reset).
- NUM_BUF=1: rd_buf=wr_buf=0 always, pending never set, stall never asserted.
- Simultaneous write completion and read swap in one cycle: evaluate the read swap first, then pick the writer's next buffer using the updated rd_buf.
- Reset, including mid-frame:
  - all counters 0, rd_buf=0, wr_buf=1 (0 if NUM_BUF=1), pending=0.
  - all pulses 0, o_wr_stall=0.
  - o_addr=0 with i_wr_n=1.

Decomposition:
- Package sram_addr_pkg: width helper function (clog2/max), buffer-index typedef, NUM_BUF range check.
- Sub-module xy_counter, instantiated twice (write and read):
  - inputs: enable, clear.
  - outputs: col/row and a last-pixel flag.
  - parameters: H_ACTIVE, V_ACTIVE.
- Buffer-allocation logic stays in the top module.

Test Plan:
All cases use ADDR_WIDTH=4, H=4, V=2, NUM_BUF=2 unless stated.
- Reset then 8 write strobes → o_addr 8,9,..,15; o_wr_frame_done on the 8th edge; o_wr_stall=1 from the next cycle.
- While stalled, 1 write strobe → o_wr_drop pulse, o_addr stays 8, write pointers unchanged.
- 8 read advances → o_addr 0..7; at the wrap o_rd_frame_done pulses, rd_buf→1, stall clears, wr_buf→0. Next reads give 8..15 and the next write gives 0.
- i_wr_n=0 and a read advance in the same cycle → write address on o_addr, read pointer unchanged. Also: i_rd_sync at read address 5 → next read address 0.
- H=5, V=2, ADDR_WIDTH=5: write advance from col 4, row 0 → next address 24 (buf 1, pitch 8).
- Assert i_rst after 3 writes → o_addr=0, all flags 0; after release the first write address is 8 again.
